// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary-to-BCD converter and the BCD add/sub datapath.
// bcd_add3 is the per-digit double-dabble correction; the adder's +6 tests reuse it.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_t;

    function automatic bcd_digit_t bcd_add3(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One BCD digit slice of a double-dabble step: add-3 correction, then shift left by one.
// bit_i enters at the LSB and the corrected MSB leaves on bit_o towards the next digit.
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       bit_i,
    output logic [3:0] digit_o,
    output logic       bit_o
);

    bcd_digit_t adj;

    assign adj     = bcd_add3(digit_i);
    assign digit_o = {adj[2:0], bit_i};
    assign bit_o   = adj[3];

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clock)
// with valid/ready handshakes on both the binary input and the BCD result.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (10 ** DIGITS <= 2 ** BIN_W) begin : g_param_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W (need 10**DIGITS > 2**BIN_W)");
    end

    b2b_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SH_W-1:0]   shreg_q;
    logic [SH_W-1:0]   shreg_d;
    logic [BCD_W-1:0]  bcd_q;
    logic              out_valid_q;
    logic [DIGITS:0]   carry;
    logic [BCD_W-1:0]  digits_d;

    assign carry[0] = shreg_q[BIN_W-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_dabble_digit u_digit (
            .digit_i (shreg_q[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .bit_i   (carry[g]),
            .digit_o (digits_d[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .bit_o   (carry[g+1])
        );
    end

    // The top digit never carries out (parameter rule), so its carry refills the vacated
    // LSB; those bits are never part of a result.
    assign shreg_d = {digits_d, shreg_q[BIN_W-2:0], carry[DIGITS]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q <= {{BCD_W{1'b0}}, bin};
                        cnt_q   <= CNT_W'(BIN_W);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q       <= shreg_d[SH_W-1 -: BCD_W];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;

endmodule
